// File: rtl/maskevent_carrier_mc_pkg.sv
// Shared types and widths for the carrier mask-event generator.
// Defining MASKEVENT_OVERRUN_EN adds the per-channel overrun counters.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 8
`endif
`ifndef MASKEV_DEC_WIDTH
`define MASKEV_DEC_WIDTH 4
`endif
`ifndef MASKEV_OVR_WIDTH
`define MASKEV_OVR_WIDTH 8
`endif

package maskevent_carrier_mc_pkg;

    typedef enum logic [1:0] {
        NO_MASK     = 2'd0,
        MIN_MASK    = 2'd1,
        MAX_MASK    = 2'd2,
        MINMAX_MASK = 2'd3
    } _mask_mode;

    localparam int DEC_W_DEFAULT = `MASKEV_DEC_WIDTH;
    localparam int OVR_W         = `MASKEV_OVR_WIDTH;

    function automatic logic mode_has_min(input _mask_mode m);
        return (m == MIN_MASK) || (m == MINMAX_MASK);
    endfunction

    function automatic logic mode_has_max(input _mask_mode m);
        return (m == MAX_MASK) || (m == MINMAX_MASK);
    endfunction

endpackage

// File: rtl/maskevent_carrier_mc_if.sv
// Bundled per-channel configuration, carrier and event signals.
// overrun_cnt exists only when MASKEVENT_OVERRUN_EN is defined.
interface maskevent_carrier_mc_if #(
    parameter int NCH  = 4,
    parameter int CW   = `PWMCOUNT_WIDTH,
    parameter int DECW = `MASKEV_DEC_WIDTH
);
    import maskevent_carrier_mc_pkg::*;

    logic                   enable;
    _mask_mode [NCH-1:0]    mask_mode;
    logic [NCH*CW-1:0]      carrier;
    logic [NCH*CW-1:0]      period;
    logic [NCH*DECW-1:0]    decim;
    logic [NCH-1:0]         ack;
    logic [NCH-1:0]         maskevent;
    logic [NCH-1:0]         pending;
`ifdef MASKEVENT_OVERRUN_EN
    logic [NCH*OVR_W-1:0]   overrun_cnt;

    modport master (
        output enable, mask_mode, carrier, period, decim, ack,
        input  maskevent, pending, overrun_cnt
    );
    modport slave (
        input  enable, mask_mode, carrier, period, decim, ack,
        output maskevent, pending, overrun_cnt
    );
`else
    modport master (
        output enable, mask_mode, carrier, period, decim, ack,
        input  maskevent, pending
    );
    modport slave (
        input  enable, mask_mode, carrier, period, decim, ack,
        output maskevent, pending
    );
`endif

endinterface

// File: rtl/maskevent_carrier_mc_channel.sv
// One mask-event channel: extremum detect, decimator, pending handshake.
// Optional saturating overrun counter under MASKEVENT_OVERRUN_EN.
module maskevent_carrier_mc_channel
    import maskevent_carrier_mc_pkg::*;
#(
    parameter int CW   = `PWMCOUNT_WIDTH,
    parameter int DECW = `MASKEV_DEC_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  _mask_mode       mask_mode,
    input  logic [CW-1:0]   carrier,
    input  logic [CW-1:0]   period,
    input  logic [DECW-1:0] decim,
    input  logic            ack,
    output logic            maskevent,
`ifdef MASKEVENT_OVERRUN_EN
    output logic [OVR_W-1:0] overrun_cnt,
`endif
    output logic            pending
);

    logic            hit_s;
    logic            qe_s;
    logic            mode_chg_s;
    logic [DECW-1:0] dec_base_s;
    logic [DECW-1:0] dec_nxt_s;
    logic            fire_s;

    logic            hit_q_r;
    _mask_mode       mode_q_r;
    logic [DECW-1:0] dec_cnt_r;
    logic            maskevent_r;
    logic            pending_r;

    // Extremum detection and decimator next-state; a mode change restarts the count
    always_comb begin
        hit_s      = ((carrier == {CW{1'b0}}) && mode_has_min(mask_mode)) ||
                     ((carrier == period)     && mode_has_max(mask_mode));
        qe_s       = hit_s & ~hit_q_r;
        mode_chg_s = (mode_q_r != mask_mode);
        fire_s     = 1'b0;
        dec_nxt_s  = dec_cnt_r;
        if (mode_chg_s) begin
            dec_base_s = {DECW{1'b0}};
        end else begin
            dec_base_s = dec_cnt_r;
        end
        if ((mask_mode == NO_MASK) || !enable) begin
            dec_nxt_s = {DECW{1'b0}};
        end else if (qe_s) begin
            if (dec_base_s >= decim) begin
                fire_s    = 1'b1;
                dec_nxt_s = {DECW{1'b0}};
            end else begin
                dec_nxt_s = dec_base_s + {{(DECW-1){1'b0}}, 1'b1};
            end
        end else if (mode_chg_s) begin
            dec_nxt_s = {DECW{1'b0}};
        end else begin
            dec_nxt_s = dec_cnt_r;
        end
    end

    // Channel state; hit_q keeps tracking while disabled so re-enable at an extremum is silent
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q_r     <= 1'b0;
            mode_q_r    <= NO_MASK;
            dec_cnt_r   <= {DECW{1'b0}};
            maskevent_r <= 1'b0;
            pending_r   <= 1'b0;
        end else begin
            hit_q_r   <= hit_s;
            mode_q_r  <= mask_mode;
            dec_cnt_r <= dec_nxt_s;
            if (mask_mode == NO_MASK) begin
                maskevent_r <= enable;
            end else begin
                maskevent_r <= fire_s;
            end
            if (fire_s) begin
                pending_r <= 1'b1;
            end else if (ack) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

`ifdef MASKEVENT_OVERRUN_EN
    logic [OVR_W-1:0] ovr_cnt_r;

    // Count fires that land on an unacknowledged pending event, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_cnt_r <= {OVR_W{1'b0}};
        end else if (fire_s && pending_r && !ack && (ovr_cnt_r != {OVR_W{1'b1}})) begin
            ovr_cnt_r <= ovr_cnt_r + {{(OVR_W-1){1'b0}}, 1'b1};
        end else begin
            ovr_cnt_r <= ovr_cnt_r;
        end
    end

    assign overrun_cnt = ovr_cnt_r;
`endif

    assign maskevent = maskevent_r;
    assign pending   = pending_r;

endmodule

// File: rtl/maskevent_carrier_mc.sv
// NCH-channel mask-event generator for the pwm8carr carrier path.
// MASKEVENT_OVERRUN_EN enables per-channel overrun counters.
module maskevent_carrier_mc
    import maskevent_carrier_mc_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CW   = `PWMCOUNT_WIDTH,
    parameter int DECW = `MASKEV_DEC_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    maskevent_carrier_mc_if.slave  bus
);

    logic [NCH-1:0] maskevent_s;
    logic [NCH-1:0] pending_s;
`ifdef MASKEVENT_OVERRUN_EN
    logic [NCH*OVR_W-1:0] overrun_s;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        maskevent_carrier_mc_channel #(
            .CW   (CW),
            .DECW (DECW)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .enable      (bus.enable),
            .mask_mode   (bus.mask_mode[i]),
            .carrier     (bus.carrier[i*CW +: CW]),
            .period      (bus.period[i*CW +: CW]),
            .decim       (bus.decim[i*DECW +: DECW]),
            .ack         (bus.ack[i]),
            .maskevent   (maskevent_s[i]),
`ifdef MASKEVENT_OVERRUN_EN
            .overrun_cnt (overrun_s[i*OVR_W +: OVR_W]),
`endif
            .pending     (pending_s[i])
        );
    end

    assign bus.maskevent = maskevent_s;
    assign bus.pending   = pending_s;
`ifdef MASKEVENT_OVERRUN_EN
    assign bus.overrun_cnt = overrun_s;
`endif

endmodule

// File: tb/tb_maskevent_carrier_mc.sv
// Directed self-checking bench for maskevent_carrier_mc.
module tb_maskevent_carrier_mc;
    import maskevent_carrier_mc_pkg::*;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int DECW = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    maskevent_carrier_mc_if #(.NCH(NCH), .CW(CW), .DECW(DECW)) bus ();

    maskevent_carrier_mc #(.NCH(NCH), .CW(CW), .DECW(DECW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_car(input int ch, input int v);
        logic [31:0] w;
        w = v;
        bus.carrier[ch*CW +: CW] = w[CW-1:0];
    endtask

    task automatic set_cfg(input int ch, input _mask_mode m, input int per, input int dec);
        logic [31:0] p;
        logic [31:0] d;
        p = per;
        d = dec;
        bus.mask_mode[ch]          = m;
        bus.period[ch*CW +: CW]    = p[CW-1:0];
        bus.decim[ch*DECW +: DECW] = d[DECW-1:0];
    endtask

    initial begin
        int c;
        int cnt;
        int bseq [21] = '{0,1,2,3,4,3,2,1,0,1,2,3,4,3,2,1,0,1,2,3,4};

        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.ack    = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            set_cfg(ch, MIN_MASK, 9, 0);
            set_car(ch, 5);
        end
        repeat (2) tick();
        check("rst_maskevent", 32'(bus.maskevent), 32'h0);
        check("rst_pending", 32'(bus.pending), 32'h0);
`ifdef MASKEVENT_OVERRUN_EN
        check("rst_overrun", 32'(bus.overrun_cnt), 32'h0);
`endif

        @(negedge clk);
        reset      = 1'b1;
        bus.enable = 1'b1;
        repeat (2) tick();
        check("idle_no_event", 32'(bus.maskevent), 32'h0);

        // Ch0 MIN_MASK up-down carrier 0..9: event only after carrier==0
        for (int p = 6; p < 38; p++) begin
            c = ((p % 18) <= 9) ? (p % 18) : (18 - (p % 18));
            set_car(0, c);
            tick();
            check("min_only", 32'(bus.maskevent[0]), 32'(c == 0));
        end
        check("min_pending", 32'(bus.pending[0]), 32'h1);
        set_car(0, 5);

        // Ch1 MINMAX_MASK decim=2: every third extremum fires
        set_cfg(1, MINMAX_MASK, 4, 2);
        set_car(1, 2);
        tick();
        for (int i = 0; i < 21; i++) begin
            set_car(1, bseq[i]);
            tick();
            check("minmax_dec2", 32'(bus.maskevent[1]), 32'((i == 8) || (i == 20)));
        end

        // Parked at 0 for 5 cycles: exactly one pulse
        cnt = 0;
        set_car(0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt += int'(bus.maskevent[0]);
        end
        check("park_one_pulse", 32'(cnt), 32'd1);

        // NO_MASK: level while enabled, zero when disabled
        bus.mask_mode[0] = NO_MASK;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nomask_level", 32'(bus.maskevent[0]), 32'h1);
        end
        bus.enable = 1'b0;
        tick();
        check("nomask_disabled", 32'(bus.maskevent), 32'h0);
        bus.enable       = 1'b1;
        bus.mask_mode[0] = MIN_MASK;
        set_car(0, 5);
        repeat (2) tick();

        // Pending handshake
        bus.ack[0] = 1'b1;
        tick();
        bus.ack[0] = 1'b0;
        check("ack_clear", 32'(bus.pending[0]), 32'h0);
        set_car(0, 0);
        tick();
        check("fire_event", 32'(bus.maskevent[0]), 32'h1);
        check("fire_pending", 32'(bus.pending[0]), 32'h1);
        set_car(0, 5);
        repeat (3) tick();
        check("pending_hold", 32'(bus.pending[0]), 32'h1);
        bus.ack[0] = 1'b1;
        tick();
        bus.ack[0] = 1'b0;
        check("ack_late_clear", 32'(bus.pending[0]), 32'h0);
        set_car(0, 0);
        bus.ack[0] = 1'b1;
        tick();
        bus.ack[0] = 1'b0;
        check("fire_ack_same", 32'(bus.pending[0]), 32'h1);
        set_car(0, 5);
        tick();
`ifdef MASKEVENT_OVERRUN_EN
        for (int i = 0; i < 300; i++) begin
            set_car(0, 0);
            tick();
            set_car(0, 5);
            tick();
        end
        check("overrun_sat", 32'(bus.overrun_cnt[7:0]), 32'd255);
        check("overrun_ch3", 32'(bus.overrun_cnt[31:24]), 32'd0);
`endif

        // period==0: min and max coincide into a single hit
        set_cfg(2, MINMAX_MASK, 0, 1);
        set_car(2, 5);
        tick();
        set_car(2, 0);
        tick();
        check("per0_first", 32'(bus.maskevent[2]), 32'h0);
        set_car(2, 1);
        tick();
        set_car(2, 0);
        tick();
        check("per0_second", 32'(bus.maskevent[2]), 32'h1);

        // Asynchronous reset mid-pulse, then re-detect on first clock
        set_car(0, 0);
        tick();
        check("pre_reset_pulse", 32'(bus.maskevent[0]), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_event", 32'(bus.maskevent), 32'h0);
        check("async_rst_pending", 32'(bus.pending), 32'h0);
        #1 reset = 1'b1;
        check("post_rel_idle", 32'(bus.maskevent), 32'h0);
        tick();
        check("post_rel_event", 32'(bus.maskevent), 32'h1);
        tick();
        check("post_rel_parked", 32'(bus.maskevent), 32'h0);

        // Lower decim 7->1 with dec_cnt=4: next qe fires
        bus.decim[0 +: DECW] = 4'd7;
        for (int i = 0; i < 4; i++) begin
            set_car(0, 5);
            tick();
            set_car(0, 0);
            tick();
            check("dec7_count", 32'(bus.maskevent[0]), 32'h0);
        end
        bus.decim[0 +: DECW] = 4'd1;
        set_car(0, 5);
        tick();
        set_car(0, 0);
        tick();
        check("dec_lowered_fire", 32'(bus.maskevent[0]), 32'h1);

        // enable=0 over an extremum: no event, pending kept, ack still works
        set_car(0, 5);
        tick();
        bus.enable = 1'b0;
        set_car(0, 0);
        tick();
        check("dis_no_event", 32'(bus.maskevent[0]), 32'h0);
        check("dis_pending_kept", 32'(bus.pending[0]), 32'h1);
        bus.enable = 1'b1;
        tick();
        check("reen_parked_silent", 32'(bus.maskevent[0]), 32'h0);
        bus.enable = 1'b0;
        bus.ack[0] = 1'b1;
        tick();
        bus.ack[0] = 1'b0;
        bus.enable = 1'b1;
        check("dis_ack_clear", 32'(bus.pending[0]), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
